// File: rtl/test_mode_ctrl_pkg.sv
`default_nettype none
// test_ctrl_pkg: shared state encoding, key defaults and counter widths
// for the test-mode entry controller.
package test_ctrl_pkg;

  localparam int KEY_W_DEF = 16;
  localparam logic [KEY_W_DEF-1:0] KEY_DEF = 16'hA5C3;
  localparam int FAIL_CNT_W = 2;
  localparam int SETTLE_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT    = 3'd1,
    CHECK    = 3'd2,
    WAIT_LOW = 3'd3,
    SETTLE   = 3'd4,
    TEST     = 3'd5,
    LOCKED   = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/test_mode_ctrl_if.sv
`default_nettype none
// test_mode_ctrl_if: external test pins in, mode/status outputs back.
interface test_mode_ctrl_if;
  import test_ctrl_pkg::*;

  logic                  test_pin;
  logic                  test_strobe;
  logic                  test_sdi;
  logic                  test_mode;
  logic                  key_err;
  logic                  locked;
  logic [FAIL_CNT_W-1:0] fail_cnt;

  modport master (
    output test_pin, test_strobe, test_sdi,
    input  test_mode, key_err, locked, fail_cnt
  );

  modport slave (
    input  test_pin, test_strobe, test_sdi,
    output test_mode, key_err, locked, fail_cnt
  );

endinterface
`default_nettype wire

// File: rtl/test_mode_ctrl_sync_2ff.sv
`default_nettype none
// sync_2ff: parameterized-width two-flop synchronizer, async active-low reset.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/test_mode_ctrl.sv
`default_nettype none
// test_mode_ctrl: serial-key unlock sequencer producing the registered,
// glitch-free test_mode select for the downstream clock mux.
module test_mode_ctrl
  import test_ctrl_pkg::*;
#(
  parameter int                KEY_W      = KEY_W_DEF,
  parameter logic [KEY_W-1:0]  KEY        = KEY_DEF,
  parameter int                SETTLE_CYC = 8,
  parameter int                MAX_TRIES  = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  test_mode_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0]        LAST_BIT    = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE     = CNT_W'(1);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE_CYC - 1);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_ONE  = SETTLE_CNT_W'(1);
  localparam logic [FAIL_CNT_W-1:0]   MAX_FAIL    = FAIL_CNT_W'(MAX_TRIES);
  localparam logic [FAIL_CNT_W-1:0]   FAIL_ONE    = FAIL_CNT_W'(1);

  logic [2:0]              sync_q;
  logic                    pin_s;
  logic                    stb_s;
  logic                    sdi_s;
  logic                    stb_q;
  logic                    stb_rise;
  state_t                  state;
  state_t                  next_state;
  logic [KEY_W-1:0]        shreg;
  logic [CNT_W-1:0]        bit_cnt;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic [FAIL_CNT_W-1:0]   fail_cnt;
  logic [FAIL_CNT_W-1:0]   fail_inc;
  logic                    key_ok;
  logic                    test_mode_d;
  logic                    key_err_d;
  logic                    locked_d;
  logic                    test_mode_q;
  logic                    key_err_q;
  logic                    locked_q;

  sync_2ff #(
    .WIDTH (3)
  ) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     ({bus.test_pin, bus.test_strobe, bus.test_sdi}),
    .q     (sync_q)
  );

  assign pin_s    = sync_q[2];
  assign stb_s    = sync_q[1];
  assign sdi_s    = sync_q[0];
  assign stb_rise = stb_s & ~stb_q;
  assign key_ok   = (shreg == KEY);
  assign fail_inc = (fail_cnt == MAX_FAIL) ? fail_cnt : fail_cnt + FAIL_ONE;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A pin release always wins over a coincident final strobe in SHIFT.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (pin_s) next_state = SHIFT;
      SHIFT: begin
        if (!pin_s)                               next_state = IDLE;
        else if (stb_rise && bit_cnt == LAST_BIT) next_state = CHECK;
      end
      CHECK: begin
        if (key_ok)                    next_state = SETTLE;
        else if (fail_inc == MAX_FAIL) next_state = LOCKED;
        else                           next_state = WAIT_LOW;
      end
      WAIT_LOW: if (!pin_s) next_state = IDLE;
      SETTLE: begin
        if (!pin_s)                         next_state = IDLE;
        else if (settle_cnt == SETTLE_LAST) next_state = TEST;
      end
      TEST:     if (!pin_s) next_state = IDLE;
      LOCKED:   next_state = LOCKED;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    test_mode_d = (next_state == TEST);
    locked_d    = (next_state == LOCKED);
    key_err_d   = (state == CHECK) && !key_ok;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      test_mode_q <= 1'b0;
      key_err_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      test_mode_q <= test_mode_d;
      key_err_q   <= key_err_d;
      locked_q    <= locked_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stb_q      <= 1'b0;
      shreg      <= '0;
      bit_cnt    <= '0;
      settle_cnt <= '0;
      fail_cnt   <= '0;
    end else begin
      stb_q <= stb_s;
      case (state)
        IDLE: begin
          shreg   <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (stb_rise) begin
            shreg   <= {sdi_s, shreg[KEY_W-1:1]};
            bit_cnt <= bit_cnt + CNT_ONE;
          end
        end
        CHECK: begin
          if (key_ok) begin
            settle_cnt <= '0;
            fail_cnt   <= '0;
          end else begin
            fail_cnt <= fail_inc;
          end
        end
        SETTLE:  settle_cnt <= settle_cnt + SETTLE_ONE;
        default: ;
      endcase
    end
  end

  assign bus.test_mode = test_mode_q;
  assign bus.key_err   = key_err_q;
  assign bus.locked    = locked_q;
  assign bus.fail_cnt  = fail_cnt;

endmodule
`default_nettype wire

// File: tb/tb_test_mode_ctrl.sv
`default_nettype none
// tb_test_mode_ctrl: table-driven key attempts plus hand sequences for
// pin release and asynchronous reset while in TEST.
module tb_test_mode_ctrl;

  localparam int SETTLE_CYC = 8;
  // strobe-to-sample (3) lands in CHECK, then SETTLE_CYC+1 to test_mode
  localparam int EXP_LAT = 3 + SETTLE_CYC + 1;

  typedef struct {
    logic [15:0] key;
    int          nbits;
    bit          drop_last;
    bit          toggle;
    int          exp_tm;
    int          exp_kerr;
    int          exp_fail;
    int          exp_lk;
  } vec_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   kerr_total;
  int   tests;
  int   fails;
  vec_t vecs[11];

  test_mode_ctrl_if bus ();

  test_mode_ctrl #(
    .KEY_W      (16),
    .KEY        (16'hA5C3),
    .SETTLE_CYC (SETTLE_CYC),
    .MAX_TRIES  (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial kerr_total = 0;
  always @(negedge clk) if (bus.key_err) kerr_total = kerr_total + 1;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_attempt(input logic [15:0] key, input int nbits,
                             input bit drop_last, input bit toggle,
                             output int lat, output int kerr);
    int k0;
    int rise_cyc;
    bus.test_pin    = 1'b0;
    bus.test_strobe = 1'b0;
    repeat (6) tick();
    k0 = kerr_total;
    bus.test_pin = 1'b1;
    repeat (5) tick();
    rise_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      bus.test_sdi = key[i];
      tick();
      bus.test_strobe = 1'b1;
      if (drop_last && i == nbits - 1) bus.test_pin = 1'b0;
      rise_cyc = cyc;
      repeat (2) tick();
      bus.test_strobe = 1'b0;
      repeat (2) tick();
    end
    if (nbits < 16) bus.test_pin = 1'b0;
    while (bus.test_mode !== 1'b1 && (cyc - rise_cyc) < 40) begin
      if (toggle) bus.test_strobe = ((((cyc - rise_cyc) / 2) % 2) == 0);
      tick();
    end
    lat = (bus.test_mode === 1'b1) ? (cyc - rise_cyc) : -1;
    for (int j = 0; j < 6; j++) begin
      if (toggle) bus.test_strobe = ((((cyc - rise_cyc) / 2) % 2) == 0);
      tick();
    end
    bus.test_strobe = 1'b0;
    kerr = kerr_total - k0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int kerr;
    tests = 0;
    fails = 0;
    cyc   = 0;
    reset_n         = 1'b0;
    bus.test_pin    = 1'b0;
    bus.test_strobe = 1'b0;
    bus.test_sdi    = 1'b0;

    //          key        nbits drop tog  tm kerr fail lk
    vecs[0]  = '{16'hA5C3, 16, 1'b0, 1'b0, 1, 0, 0, 0};
    vecs[1]  = '{16'h0000, 16, 1'b0, 1'b0, 0, 1, 1, 0};
    vecs[2]  = '{16'hA5C3, 16, 1'b0, 1'b0, 1, 0, 0, 0};
    vecs[3]  = '{16'hA5C3, 16, 1'b0, 1'b1, 1, 0, 0, 0};
    vecs[4]  = '{16'h1234, 10, 1'b0, 1'b0, 0, 0, 0, 0};
    vecs[5]  = '{16'hFFFF, 16, 1'b0, 1'b0, 0, 1, 1, 0};
    vecs[6]  = '{16'h0F0F, 16, 1'b1, 1'b0, 0, 0, 1, 0};
    vecs[7]  = '{16'hA5C4, 10, 1'b0, 1'b0, 0, 0, 1, 0};
    vecs[8]  = '{16'h5A3C, 16, 1'b0, 1'b0, 0, 1, 2, 0};
    vecs[9]  = '{16'h0001, 16, 1'b0, 1'b0, 0, 1, 3, 1};
    vecs[10] = '{16'hA5C3, 16, 1'b0, 1'b0, 0, 0, 3, 1};

    repeat (3) tick();
    check("rst_test_mode", int'(bus.test_mode), 0);
    check("rst_key_err",   int'(bus.key_err),   0);
    check("rst_locked",    int'(bus.locked),    0);
    check("rst_fail_cnt",  int'(bus.fail_cnt),  0);
    reset_n = 1'b1;
    repeat (2) tick();

    for (int v = 0; v < 11; v++) begin
      run_attempt(vecs[v].key, vecs[v].nbits, vecs[v].drop_last,
                  vecs[v].toggle, lat, kerr);
      check($sformatf("v%0d_test_mode", v), int'(bus.test_mode), vecs[v].exp_tm);
      check($sformatf("v%0d_key_err_cycles", v), kerr, vecs[v].exp_kerr);
      check($sformatf("v%0d_fail_cnt", v), int'(bus.fail_cnt), vecs[v].exp_fail);
      check($sformatf("v%0d_locked", v), int'(bus.locked), vecs[v].exp_lk);
      if (vecs[v].exp_tm == 1) check($sformatf("v%0d_tm_latency", v), lat, EXP_LAT);
    end

    // Reset pulse out of LOCKED clears every output.
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("unlock_test_mode", int'(bus.test_mode), 0);
    check("unlock_key_err",   int'(bus.key_err),   0);
    check("unlock_locked",    int'(bus.locked),    0);
    check("unlock_fail_cnt",  int'(bus.fail_cnt),  0);

    // Pin release from TEST: test_mode falls on the third edge.
    run_attempt(16'hA5C3, 16, 1'b0, 1'b0, lat, kerr);
    check("relock_latency", lat, EXP_LAT);
    bus.test_pin = 1'b0;
    tick();
    check("pin_fall_c1", int'(bus.test_mode), 1);
    tick();
    check("pin_fall_c2", int'(bus.test_mode), 1);
    tick();
    check("pin_fall_c3", int'(bus.test_mode), 0);

    // Asynchronous reset from TEST, observed before any clock edge.
    run_attempt(16'hA5C3, 16, 1'b0, 1'b0, lat, kerr);
    check("pre_rst_test_mode", int'(bus.test_mode), 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_test_mode", int'(bus.test_mode), 0);
    tick();
    reset_n = 1'b1;
    bus.test_pin = 1'b0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/test_mode_ctrl.md
# test_mode_ctrl

Test-mode entry controller that generates the `test_mode` select consumed by the clock-mux stage, which switches every functional clock to `scan_clk`. The block accepts a serial unlock key on external test pins and asserts `test_mode` only after a correct key and a settle interval. It drops `test_mode` cleanly when the test pin is released and locks out after repeated bad keys. It runs on the functional `clk`, upstream of the clock mux, so its output must be a registered, glitch-free level.

## Interface
Parameters:
- `KEY_W`, 16: unlock key width in bits.
- `KEY`, 16'hA5C3: unlock key value, shifted in LSB first.
- `SETTLE_CYC`, 8: `clk` cycles between key match and `test_mode` assertion (range 1..255).
- `MAX_TRIES`, 3: bad-key attempts before lockout (range 1..3).

Ports:
- `clk`, in, 1: functional clock. One clock domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `test_pin`, in, 1: asynchronous test-request pin. Level-sensitive.
- `test_strobe`, in, 1: asynchronous key-bit strobe. Sampling is on the rising edge.
- `test_sdi`, in, 1: asynchronous serial key data.
- `test_mode`, out, 1: registered select for the clock mux.
- `key_err`, out, 1: one-cycle pulse on a key mismatch.
- `locked`, out, 1: level, asserted after `MAX_TRIES` mismatches.
- `fail_cnt`, out, 2: count of mismatches since reset or since the last successful entry.

## Operation
- `test_pin`, `test_strobe` and `test_sdi` each pass through a 2-flop synchronizer, giving `pin_s`, `stb_s` and `sdi_s`.
- `stb_rise` is `stb_s & ~stb_q`, where `stb_q` is one extra flop.
- State machine states and transitions:
  - IDLE:
    - `pin_s`=1: go to SHIFT, clear `bit_cnt` and `shreg`.
  - SHIFT:
    - On each `stb_rise`, `shreg <= {sdi_s, shreg[KEY_W-1:1]}` and `bit_cnt++`.
    - When `bit_cnt` reaches `KEY_W`: go to CHECK.
    - `pin_s`=0: go to IDLE. This is an abort and does not count as a failure.
  - CHECK (1 cycle):
    - `shreg==KEY`: go to SETTLE, clear `settle_cnt`, clear `fail_cnt`.
    - Otherwise, pulse `key_err` and `fail_cnt++`. If the new `fail_cnt` equals `MAX_TRIES`, go to LOCKED; otherwise go to WAIT_LOW.
  - WAIT_LOW:
    - `pin_s`=0: go to IDLE. A fresh attempt requires a new pin assertion.
  - SETTLE:
    - `settle_cnt++` each cycle; `test_mode` stays 0 so functional clocks can quiesce.
    - At `SETTLE_CYC`: go to TEST.
    - `pin_s`=0 at any point: go to IDLE.
  - TEST:
    - `test_mode`=1.
    - `pin_s`=0: go to IDLE.
  - LOCKED:
    - `locked`=1. Absorbing; only `reset_n` leaves this state.
- `stb_rise` is ignored in every state except SHIFT.
- `fail_cnt` saturates at `MAX_TRIES`.
- `test_mode` is a flop decoded from next-state==TEST. It has no combinational path to the output.

## Timing
- Reset values: `test_mode`=0, `key_err`=0, `locked`=0, `fail_cnt`=0, state=IDLE, all synchronizer and counter flops=0.
- Pin-to-SHIFT latency: 3 `clk` cycles (2 sync cycles plus 1 FSM cycle).
- Strobe-to-sample latency: 3 `clk` cycles after the `test_strobe` rise.
- `test_sdi` must be stable from 1 cycle before to 3 cycles after the strobe rise.
- The minimum `test_strobe` high time and low time are each 2 `clk` cycles.
- `test_mode` rises exactly `SETTLE_CYC`+1 cycles after CHECK.
- After `test_pin` falls, `test_mode` falls 3 cycles later.
- The clock mux output may glitch once at switch time. This is accepted, because the mux is intended for static mode changes.
- `reset_n` assertion mid-operation (including in TEST) forces `test_mode` to 0 asynchronously.
- If `pin_s` falls in the same cycle as the last key bit's `stb_rise`, the pin fall wins: go to IDLE with no CHECK and no failure counted.

## Structure
- Package `test_ctrl_pkg` holds:
  - the state enum (IDLE, SHIFT, CHECK, WAIT_LOW, SETTLE, TEST, LOCKED);
  - `KEY_W_DEF` and `KEY_DEF`;
  - the `fail_cnt` width constant.
- Sub-module `sync_2ff` is a parameterized-width 2-flop synchronizer with async active-low reset, reusable elsewhere. Instantiate it once, at width 3.

## Test plan
- Reset, raise `test_pin`, shift 16'hA5C3 LSB first with `SETTLE_CYC`=8 -> `test_mode`=1 exactly 9 cycles after CHECK; `key_err` never pulses; `fail_cnt`=0.
- Shift 16'h0000 -> `key_err` one-cycle pulse, `fail_cnt`=1, `test_mode`=0. Drop and re-raise `test_pin`, then shift the correct key -> `test_mode`=1 and `fail_cnt`=0.
- Three consecutive bad keys (pin toggled between attempts) -> `locked`=1 and `fail_cnt`=3. A following correct key leaves `test_mode`=0. Pulsing `reset_n` clears all outputs.
- Drop `test_pin` after 10 key bits -> return to IDLE, `fail_cnt` unchanged, no `key_err`.
- In TEST, drop `test_pin` -> `test_mode` falls 3 cycles later. Separately, in TEST, assert `reset_n`=0 -> `test_mode`=0 immediately, without waiting for a clock edge.
- Toggle `test_strobe` during SETTLE and TEST -> no state change, and `test_mode` timing is identical to the first scenario.
